// File: rtl/glyph_row_scheduler_if.sv
// Signal bundle between the glyph row scheduler and its surroundings (timing, config, font ROM,
// colour mux).
interface glyph_row_scheduler_if;
  logic        clk_en;
  logic [10:0] h_count;
  logic [10:0] v_count;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [10:0] cfg_x;
  logic [10:0] cfg_y;
  logic [3:0]  cfg_bcd;
  logic        cfg_en;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        pixon;
  logic        busy;
  logic        overrun;

  modport master (
    output clk_en, h_count, v_count, cfg_we, cfg_addr, cfg_x, cfg_y, cfg_bcd, cfg_en, rom_data,
    input  rom_en, rom_addr, pixon, busy, overrun
  );

  modport slave (
    input  clk_en, h_count, v_count, cfg_we, cfg_addr, cfg_x, cfg_y, cfg_bcd, cfg_en, rom_data,
    output rom_en, rom_addr, pixon, busy, overrun
  );
endinterface

// File: rtl/glyph_row_scheduler.sv
// Fetches next-line glyph rows for every digit cell from one shared font ROM during hblank,
// then serialises the swapped-in rows into a single registered pixon stream.
module glyph_row_scheduler #(
  parameter int unsigned NUM_CELLS = 27,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_TOTAL   = 525
) (
  input logic                  clk,
  input logic                  reset,
  glyph_row_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StScan, StLast, StDone} state_e;

  localparam logic [4:0] LastIdx = 5'(NUM_CELLS - 1);

  // Cell table
  logic [10:0]          tab_x   [NUM_CELLS];
  logic [10:0]          tab_y   [NUM_CELLS];
  logic [3:0]           tab_bcd [NUM_CELLS];
  logic [NUM_CELLS-1:0] tab_en;

  // Shadow (being fetched) and active (being displayed) row sets
  logic [7:0]           shadow_row [NUM_CELLS];
  logic [10:0]          shadow_x   [NUM_CELLS];
  logic [NUM_CELLS-1:0] shadow_hit;
  logic [7:0]           active_row [NUM_CELLS];
  logic [10:0]          active_x   [NUM_CELLS];
  logic [NUM_CELLS-1:0] active_hit;

  state_e      state_q;
  logic [4:0]  idx_q;
  logic [10:0] line_q;
  logic        rom_en_q;
  logic [7:0]  rom_addr_q;
  logic        cap_q;
  logic [4:0]  cap_idx_q;
  logic        busy_q;
  logic        pixon_q;
  logic        overrun_q;

  logic        trig;
  logic        swap;
  logic [10:0] l_now;
  logic        look_valid;
  logic [4:0]  look_idx;
  logic [10:0] look_line;
  logic [10:0] lk_x;
  logic [10:0] lk_y;
  logic [3:0]  lk_bcd;
  logic        lk_en;
  logic [10:0] lk_diff;
  logic        lk_hit;
  logic        pix_d;

  assign trig  = bus.clk_en && (bus.h_count == 11'(H_ACTIVE));
  assign swap  = bus.clk_en && (bus.h_count == 11'd0);
  assign l_now = (bus.v_count == 11'(V_TOTAL - 1)) ? 11'd0 : bus.v_count + 11'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CELLS); i++) begin
        tab_x[i]   <= '0;
        tab_y[i]   <= '0;
        tab_bcd[i] <= '0;
      end
      tab_en <= '0;
    end else if (bus.cfg_we && ({27'd0, bus.cfg_addr} < NUM_CELLS)) begin
      tab_x[bus.cfg_addr]   <= bus.cfg_x;
      tab_y[bus.cfg_addr]   <= bus.cfg_y;
      tab_bcd[bus.cfg_addr] <= bus.cfg_bcd;
      tab_en[bus.cfg_addr]  <= bus.cfg_en;
    end
  end

  // The cell visited in the next cycle is looked up now so rom_en/rom_addr leave a register.
  always_comb begin
    look_valid = trig || ((state_q == StScan) && (idx_q != LastIdx));
    look_idx   = trig ? 5'd0 : idx_q + 5'd1;
    look_line  = trig ? l_now : line_q;
    if (!look_valid) look_idx = 5'd0;
    lk_x    = tab_x[look_idx];
    lk_y    = tab_y[look_idx];
    lk_bcd  = tab_bcd[look_idx];
    lk_en   = tab_en[look_idx];
    lk_diff = look_line - lk_y;
    lk_hit  = lk_en && (lk_bcd <= 4'd9) && (look_line >= lk_y) && (lk_diff < 11'd16);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      line_q     <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      cap_q      <= 1'b0;
      cap_idx_q  <= '0;
      busy_q     <= 1'b0;
      shadow_hit <= '0;
      for (int i = 0; i < int'(NUM_CELLS); i++) begin
        shadow_row[i] <= '0;
        shadow_x[i]   <= '0;
      end
    end else begin
      if (cap_q) begin
        shadow_row[cap_idx_q] <= bus.rom_data;
        shadow_hit[cap_idx_q] <= 1'b1;
      end
      cap_q     <= rom_en_q;
      cap_idx_q <= idx_q;

      if (look_valid) begin
        idx_q              <= look_idx;
        shadow_x[look_idx] <= lk_x;
        rom_en_q           <= lk_hit;
        rom_addr_q         <= {lk_bcd, lk_diff[3:0]};
        if (!lk_hit) begin
          shadow_row[look_idx] <= '0;
          shadow_hit[look_idx] <= 1'b0;
        end
      end else begin
        rom_en_q <= 1'b0;
      end

      // A trigger in any state restarts the fetch and drops partial shadow data.
      if (trig) begin
        state_q    <= StScan;
        line_q     <= l_now;
        busy_q     <= 1'b1;
        shadow_hit <= '0;
        cap_q      <= 1'b0;
      end else begin
        unique case (state_q)
          StScan:  if (idx_q == LastIdx) state_q <= StLast;
          StLast:  state_q <= StDone;
          StDone: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic cell_on(input logic hit, input logic [7:0] row,
                                   input logic [10:0] x, input logic [10:0] h);
    logic [10:0] dx;
    dx = h - x;
    return hit && (h >= x) && (dx < 11'd8) && row[3'd7 - dx[2:0]];
  endfunction

  always_comb begin
    pix_d = 1'b0;
    for (int i = 0; i < int'(NUM_CELLS); i++) begin
      pix_d = pix_d | cell_on(active_hit[i], active_row[i], active_x[i], bus.h_count);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_hit <= '0;
      for (int i = 0; i < int'(NUM_CELLS); i++) begin
        active_row[i] <= '0;
        active_x[i]   <= '0;
      end
      pixon_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (swap) begin
        active_row <= shadow_row;
        active_x   <= shadow_x;
        active_hit <= shadow_hit;
        if (busy_q) overrun_q <= 1'b1;
      end
      pixon_q <= pix_d;
    end
  end

  assign bus.rom_en   = rom_en_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.pixon    = pixon_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_glyph_row_scheduler.sv
// Scoreboard bench: stimulus pushes expected ROM strobes, pixels and busy lengths; a negedge
// monitor pops and compares them as the scheduler presents outputs.
module tb_glyph_row_scheduler;
  localparam int NC = 27;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  glyph_row_scheduler_if bus();

  glyph_row_scheduler #(
    .NUM_CELLS(27),
    .H_ACTIVE (640),
    .V_TOTAL  (525)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {int due; logic [7:0] addr;} rom_exp_t;
  typedef struct {int due; logic val;} pix_exp_t;
  rom_exp_t rom_q[$];
  pix_exp_t pix_q[$];
  int       busy_q[$];
  int       tcyc;

  int         tx [NC];
  int         ty [NC];
  logic [3:0] tb_bcd [NC];
  logic       ten [NC];

  function automatic logic [7:0] font(input logic [7:0] a);
    return {a[2:0], a[7:3]} ^ 8'h96;
  endfunction

  // Font ROM model: data valid exactly one clock after the strobe.
  always @(posedge clk) bus.rom_data <= bus.rom_en ? font(bus.rom_addr) : 8'hE7;

  function automatic logic exp_pix(input int h, input int l);
    logic [7:0] row;
    for (int c = 0; c < NC; c++) begin
      if (ten[c] && tb_bcd[c] <= 4'd9 && l >= ty[c] && l - ty[c] < 16) begin
        row = font({tb_bcd[c], 4'(l - ty[c])});
        if (h >= tx[c] && h - tx[c] < 8 && row[7 - (h - tx[c])]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h), cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input int exp);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got no output, required 0x%0h, cycle %0d", name, exp, cyc);
  endtask

  int busy_run = 0;
  always @(negedge clk) begin
    if (!reset) begin
      while (rom_q.size() > 0 && rom_q[0].due < cyc) begin
        flag("rom_en_missing", rom_q[0].addr);
        void'(rom_q.pop_front());
      end
      if (bus.rom_en) begin
        if (rom_q.size() > 0 && rom_q[0].due == cyc) begin
          chk("rom_addr", bus.rom_addr, rom_q[0].addr);
          void'(rom_q.pop_front());
        end else begin
          n_cmp++;
          n_err++;
          $display("FAIL rom_en_unexpected: got strobe addr 0x%0h, required none, cycle %0d",
                   bus.rom_addr, cyc);
        end
      end
      while (pix_q.size() > 0 && pix_q[0].due < cyc) begin
        flag("pixon_missing", pix_q[0].val);
        void'(pix_q.pop_front());
      end
      if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
        chk("pixon", bus.pixon, pix_q[0].val);
        void'(pix_q.pop_front());
      end
      if (bus.busy) begin
        busy_run++;
      end else if (busy_run > 0) begin
        if (busy_q.size() > 0) chk("busy_len", busy_run, busy_q.pop_front());
        busy_run = 0;
      end
    end else begin
      busy_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cell(input int i, input int x, input int y, input int b, input bit e);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 5'(i);
    bus.cfg_x    = 11'(x);
    bus.cfg_y    = 11'(y);
    bus.cfg_bcd  = 4'(b);
    bus.cfg_en   = e;
    tick();
    bus.cfg_we = 1'b0;
    if (i < NC) begin
      tx[i] = x; ty[i] = y; tb_bcd[i] = 4'(b); ten[i] = e;
    end
  endtask

  task automatic trig_start(input int v);
    bus.v_count = 11'(v);
    bus.h_count = 11'd640;
    bus.clk_en  = 1'b1;
    tcyc = cyc;
    busy_q.push_back(29);
  endtask

  task automatic trig_finish();
    tick();
    bus.clk_en  = 1'b0;
    bus.h_count = 11'd700;
    repeat (32) tick();
  endtask

  task automatic push_rom(input int off, input int addr);
    rom_exp_t e;
    e.due  = tcyc + 1 + off;
    e.addr = 8'(addr);
    rom_q.push_back(e);
  endtask

  task automatic swap_scan(input int v, input int w);
    pix_exp_t e;
    bus.v_count = 11'(v);
    bus.h_count = 11'd0;
    bus.clk_en  = 1'b1;
    tick();
    for (int h = 1; h <= w; h++) begin
      bus.h_count = 11'(h);
      e.due = cyc + 1;
      e.val = exp_pix(h, v);
      pix_q.push_back(e);
      tick();
    end
    bus.clk_en  = 1'b0;
    bus.h_count = 11'd700;
    tick();
    tick();
  endtask

  int hl;

  initial begin
    for (int c = 0; c < NC; c++) begin
      tx[c] = 0; ty[c] = 0; tb_bcd[c] = 4'd0; ten[c] = 1'b0;
    end
    bus.clk_en = 1'b0; bus.h_count = 11'd700; bus.v_count = 11'd0;
    bus.cfg_we = 1'b0; bus.cfg_addr = 5'd0; bus.cfg_x = 11'd0; bus.cfg_y = 11'd0;
    bus.cfg_bcd = 4'd0; bus.cfg_en = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_rom_en", bus.rom_en, 0);
    chk("reset_rom_addr", bus.rom_addr, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_pixon", bus.pixon, 0);
    chk("reset_overrun", bus.overrun, 0);
    reset = 1'b0;
    tick();

    // Single cell, line 50, row 0 of digit 1
    set_cell(0, 100, 50, 1, 1'b1);
    trig_start(49); push_rom(0, 8'h10); trig_finish();
    swap_scan(50, 199);

    // Last glyph row, then one line past the glyph
    trig_start(64); push_rom(0, 8'h1F); trig_finish();
    swap_scan(65, 199);
    trig_start(65); trig_finish();
    swap_scan(66, 199);

    // Frame wrap to line 0
    set_cell(0, 20, 0, 7, 1'b1);
    trig_start(524); push_rom(0, 8'h70); trig_finish();
    swap_scan(0, 199);

    // Non-digit code, disabled cell, out-of-range write
    set_cell(0, 100, 50, 4'hA, 1'b1);
    set_cell(1, 100, 50, 3, 1'b0);
    set_cell(27, 100, 49, 2, 1'b1);
    trig_start(49); trig_finish();
    swap_scan(50, 199);

    // Overlapping cells
    set_cell(0, 100, 50, 1, 1'b1);
    set_cell(1, 104, 50, 3, 1'b1);
    trig_start(49); push_rom(0, 8'h10); push_rom(1, 8'h30); trig_finish();
    swap_scan(50, 199);

    // Every cell hits
    for (int i = 0; i < NC; i++) set_cell(i, 8 + 8 * i, 10, i % 10, 1'b1);
    trig_start(10);
    for (int i = 0; i < NC; i++) push_rom(i, {4'(i % 10), 4'h1});
    trig_finish();
    swap_scan(11, 239);

    // Swap while busy
    chk("overrun_before", bus.overrun, 0);
    trig_start(20);
    for (int i = 0; i < NC; i++) push_rom(i, {4'(i % 10), 4'hB});
    tick();
    bus.clk_en = 1'b0; bus.h_count = 11'd700;
    repeat (9) tick();
    bus.h_count = 11'd0; bus.clk_en = 1'b1;
    tick();
    bus.clk_en = 1'b0; bus.h_count = 11'd700;
    chk("overrun_set", bus.overrun, 1);
    repeat (25) tick();
    chk("overrun_held", bus.overrun, 1);
    swap_scan(21, 239);
    chk("overrun_sticky", bus.overrun, 1);

    // Reset in the middle of a scan
    hl = 0;
    for (int h = 239; h >= 1; h--) if (exp_pix(h, 21)) hl = h;
    trig_start(22 - 1);
    for (int i = 0; i < NC; i++) push_rom(i, {4'(i % 10), 4'hC});
    tick();
    bus.clk_en = 1'b0; bus.h_count = 11'(hl);
    repeat (3) tick();
    chk("pre_reset_pixon", bus.pixon, 1);
    chk("pre_reset_busy", bus.busy, 1);
    chk("pre_reset_rom_en", bus.rom_en, 1);
    rom_q.delete();
    busy_q.delete();
    reset = 1'b1;
    #1;
    chk("midreset_rom_en", bus.rom_en, 0);
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_pixon", bus.pixon, 0);
    chk("midreset_overrun", bus.overrun, 0);
    repeat (2) tick();
    reset = 1'b0;
    bus.h_count = 11'd700;
    tick();
    for (int c = 0; c < NC; c++) ten[c] = 1'b0;

    // Table enables cleared by reset: no strobes
    trig_start(10); trig_finish();
    swap_scan(11, 239);

    repeat (3) tick();
    chk("rom_leftover", rom_q.size(), 0);
    chk("pix_leftover", pix_q.size(), 0);
    chk("busy_leftover", busy_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/glyph_row_scheduler.md
# glyph_row_scheduler

Shared font-ROM scheduler for the on-screen digit matrix. It holds a table of digit cells, each with a position, a BCD value and an enable. During each horizontal blank it fetches, from one shared 8x16 font ROM, the glyph row that every cell needs on the next scanline. During active video it serialises those rows into a single `pixon` stream for the colour mux. It sits between the horizontal/vertical counters and the RGB output, and replaces per-digit ROM lookups.

## Interface
Parameters:
- `NUM_CELLS`, 27: number of digit cells in the table (max 32).
- `H_ACTIVE`, 640: first hblank pixel; the fetch trigger.
- `V_TOTAL`, 525: total lines per frame; used for next-line wrap.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `clk_en` in 1: pixel-rate enable from the clock divider.
- `h_count` in 11: current pixel column.
- `v_count` in 11: current line.
- `cfg_we` in 1: cell-table write strobe.
- `cfg_addr` in 5: cell index; writes with index >= `NUM_CELLS` are ignored.
- `cfg_x` in 11: cell left column.
- `cfg_y` in 11: cell top line.
- `cfg_bcd` in 4: digit code.
- `cfg_en` in 1: cell visible.
- `rom_en` out 1: font ROM read strobe.
- `rom_addr` out 8: ROM address = {bcd, glyph row}.
- `rom_data` in 8: ROM row data, valid exactly 1 clk after `rom_en`; MSB is the leftmost pixel.
- `pixon` out 1: registered pixel-on.
- `busy` out 1: fetch in progress.
- `overrun` out 1: sticky; set when a line swap occurs while `busy`.

## Operation
- Cell table: `NUM_CELLS` x {x, y, bcd, en}.
  - Written on `cfg_we` at any time.
  - A fetch uses the values sampled in the cycle the cell is visited.
- Trigger: `clk_en` && `h_count == H_ACTIVE`.
  - Target line `L = (v_count == V_TOTAL-1) ? 0 : v_count+1`.
- FSM states: IDLE, SCAN, LAST, DONE.
  - IDLE -> SCAN on trigger; index i = 0.
  - SCAN visits one cell per clk (not gated by `clk_en`).
  - A cell hits if `en && bcd <= 9 && L >= y && L - y < 16` (11-bit unsigned compare, no wrap).
  - On hit: `rom_en = 1`, `rom_addr = {bcd, (L-y)[3:0]}`.
  - On miss: `rom_en = 0`, `shadow_row[i] = 0`, `shadow_hit[i] = 0`.
  - SCAN -> LAST after i = `NUM_CELLS-1`.
  - LAST: captures the last pending `rom_data`.
  - LAST -> DONE -> IDLE.
- Capture: `rom_data` is written into `shadow_row[i-1]`, and `shadow_hit[i-1] = 1`, one clk after that cell's `rom_en`.
- A trigger while not IDLE restarts SCAN at i = 0 and discards partial shadow data.
- Swap: on `clk_en && h_count == 0`, the shadow {row, hit, x} is copied to the active set.
  - If `busy` at the swap, the swap still occurs and `overrun` is set.
  - `overrun` clears only on reset.
- Display (every clk):
  - Cell term = `active_hit[i] && h_count >= x && h_count - x < 8 && active_row[i][7 - (h_count - x)]`.
  - `pixon` is the registered OR over all cells; overlapping cells OR together.
- Reset values: all outputs 0; FSM IDLE; every table `en` = 0; shadow and active cleared.
- Reset asserted mid-fetch aborts immediately with no partial swap.

## Timing
- Trigger seen at cycle T:
  - Cell i is visited (and `rom_en` issued if it hits) at T+1+i.
  - `rom_data` is captured at T+2+i.
  - `busy` is high from T+1 through T+`NUM_CELLS`+2.
  - IDLE at T+`NUM_CELLS`+3.
- With default divide-by-4, hblank is 160 px = 640 clks, far more than the 30 clks the fetch needs.
- `pixon` latency is 1 clk from `h_count`. The colour mux uses it directly; `hblank` gates the output externally.
- A `cfg_we` in the same cycle that the cell is visited: the fetch uses the old entry. The write lands at the clock edge.

## Test plan
- Cell 0 = {x=100, y=50, bcd=1, en=1}, `v_count`=49, trigger.
  - Expect `rom_addr` = 0x10 at T+1.
  - After swap on line 50, `pixon` follows the ROM row bits for h=100..107, 1 clk late, and is 0 elsewhere.
- Cell with y=50; target lines 65 and 66.
  - Line 65: `rom_addr` low nibble = 0xF.
  - Line 66: no `rom_en`, `pixon` stays 0.
- `v_count` = 524 with a cell at y=0, bcd=7.
  - Expect L=0 and `rom_addr` = 0x70.
- Cell bcd=0xA, or `en`=0: no `rom_en` for that cell and `pixon` stays 0.
  - A `cfg_addr` of 27 write leaves the table unchanged.
- Two cells overlapping at x=100 and x=104: `pixon` is the OR of both rows.
  - All 27 cells hit: 27 consecutive `rom_en` pulses, `busy` for 29 clks.
- Force an `h_count` = 0 swap 10 clks after the trigger: `overrun` = 1 and stays 1.
  - Reset mid-SCAN: `rom_en`, `busy`, `pixon` go to 0 immediately.
